// File: rtl/motor_pkg.sv
// motor_pkg: state encoding, PWM period top and command field layout
// shared by the motor PWM driver and its timebase.
package motor_pkg;
  typedef enum logic [1:0] {RUN, RAMPDOWN, DEAD} state_e;
  localparam logic [7:0] PWM_TOP = 8'd254;
  localparam int CMD_DIR_BIT = 8;
  localparam int CMD_DUTY_MSB = 7;
endpackage

// File: rtl/motor_pwm_timebase.sv
// motor_pwm_timebase: prescaler plus 0..PWM_TOP period counter; boundary
// marks the last tick of each PWM period.
module motor_pwm_timebase
  import motor_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       tick,
  output logic [7:0] cnt,
  output logic       boundary
);
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_TOP = PW'(CLK_DIV - 1);
  logic [PW-1:0] pre_q;
  logic [7:0]    cnt_q;
  assign tick     = pre_q == PRE_TOP;
  assign boundary = tick && cnt_q == PWM_TOP;
  assign cnt      = cnt_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= tick ? '0 : pre_q + 1'b1;
      cnt_q <= boundary ? '0 : tick ? cnt_q + 1'b1 : cnt_q;
    end
  end
endmodule

// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver: slew-limited PWM H-bridge driver with forced
// ramp-down and dead time on every direction reversal.
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int RAMP_STEP    = 8,
  parameter int DEAD_PERIODS = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [8:0] cmd,
  input  logic       enable,
  output logic       pwm_out,
  output logic       dir_a,
  output logic       dir_b,
  output logic [7:0] duty_cur,
  output logic       dir_cur,
  output logic       reversing
);
  localparam logic [7:0] STEP   = 8'(RAMP_STEP);
  localparam logic [7:0] DEAD_N = 8'(DEAD_PERIODS);
  logic       tick_unused, boundary;
  logic [7:0] cnt;
  state_e     state_q, state_d;
  logic [7:0] duty_q, duty_d, dead_q, dead_d;
  logic       dir_q, dir_d, pwm_q, pwm_d, dir_a_q, dir_a_d, dir_b_q, dir_b_d;
  logic [7:0] tgt, dn, ramp;
  logic       tdir, upd;

  motor_pwm_timebase #(.CLK_DIV(CLK_DIV)) u_tb (
    .clk      (clk),
    .reset_n  (reset_n),
    .tick     (tick_unused),
    .cnt      (cnt),
    .boundary (boundary)
  );

  assign tgt  = cmd[CMD_DUTY_MSB:0];
  assign tdir = cmd[CMD_DIR_BIT];
  assign dn   = duty_q > STEP ? duty_q - STEP : '0;
  // Step toward the target without ever overshooting it, so no 8-bit wrap.
  assign ramp = tgt > duty_q ? (tgt - duty_q > STEP ? duty_q + STEP : tgt)
                             : (duty_q - tgt > STEP ? duty_q - STEP : tgt);
  assign upd  = !enable || boundary;

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    dead_d  = dead_q;
    if (!enable) begin
      state_d = RUN;
      duty_d  = '0;
      dead_d  = '0;
    end else if (boundary) begin
      case (state_q)
        RUN: begin
          duty_d = tdir != dir_q ? dn : ramp;
          if (tdir != dir_q) begin
            state_d = dn == '0 ? DEAD : RAMPDOWN;
            dead_d  = dn == '0 ? DEAD_N : dead_q;
          end
        end
        RAMPDOWN: begin
          duty_d  = tdir == dir_q ? duty_q : dn;
          state_d = tdir == dir_q ? RUN : dn == '0 ? DEAD : RAMPDOWN;
          dead_d  = tdir != dir_q && dn == '0 ? DEAD_N : dead_q;
        end
        DEAD: begin
          dead_d  = dead_q - 8'd1;
          state_d = dead_q <= 8'd1 ? RUN : DEAD;
          dir_d   = dead_q <= 8'd1 ? tdir : dir_q;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign pwm_d   = enable && state_q == RUN && cnt < duty_q;
  assign dir_a_d = upd ? state_d != DEAD && !dir_d : dir_a_q;
  assign dir_b_d = upd ? state_d != DEAD && dir_d : dir_b_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      duty_q  <= '0;
      dir_q   <= 1'b0;
      dead_q  <= '0;
      pwm_q   <= 1'b0;
      dir_a_q <= 1'b0;
      dir_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      dead_q  <= dead_d;
      pwm_q   <= pwm_d;
      dir_a_q <= dir_a_d;
      dir_b_q <= dir_b_d;
    end
  end

  assign pwm_out   = pwm_q;
  assign dir_a     = dir_a_q;
  assign dir_b     = dir_b_q;
  assign duty_cur  = duty_q;
  assign dir_cur   = dir_q;
  assign reversing = state_q != RUN;
endmodule

// File: doc/motor_pwm_driver.md
# motor_pwm_driver

Converts the 9-bit motor command from the HPS motor PIOs into H-bridge drive signals. One instance sits downstream of `motor_left_external_connection_export` and one downstream of `motor_right_external_connection_export`, in the same clock domain. Each instance:

- generates a fixed-period PWM;
- slew-limits duty changes;
- forces a ramp-down plus dead-time sequence on every direction reversal, so the bridge never flips direction under load.

## Interface

Parameters:
- `CLK_DIV`, default 4: clk cycles per PWM tick (≥1). 50 MHz / 4 / 255 ≈ 49 kHz.
- `RAMP_STEP`, default 8: maximum duty change per PWM period (1..255).
- `DEAD_PERIODS`, default 4: PWM periods with the bridge fully off during a reversal (≥1).

Ports:
- `clk` in 1: system clock, same domain as the PIO.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd` in 9: `[8]` direction (0 = forward, 1 = reverse), `[7:0]` duty magnitude 0..255.
- `enable` in 1: synchronous enable; low forces the motor to coast.
- `pwm_out` out 1: bridge enable/PWM, registered.
- `dir_a` out 1: bridge input A, high when driving forward.
- `dir_b` out 1: bridge input B, high when driving reverse.
- `duty_cur` out 8: duty currently applied.
- `dir_cur` out 1: direction currently applied.
- `reversing` out 1: high while in RAMPDOWN or DEAD.

## Operation

Reset (asynchronous): all outputs 0, state RUN, all counters 0, target 0.

PWM generation:
- Prescaler issues a `tick` every `CLK_DIV` clks.
- Period counter `cnt` runs 0..254 on ticks, giving a 255-tick period.
- Boundary = `tick && cnt==254`.
- `pwm_out <= (state==RUN) && (cnt < duty_cur)`. Duty 0 gives always low; duty 255 gives always high.

Command sampling: `cmd` is sampled into target_dir/target_duty at each boundary only. Mid-period changes have no effect until then.

State machine (updates at boundaries only):
- RUN:
  - if target_dir ≠ dir_cur: go to RAMPDOWN if duty_cur>0, otherwise go to DEAD and load dead_cnt = `DEAD_PERIODS`.
  - else: duty_cur moves toward target_duty by min(`RAMP_STEP`, |diff|).
- RAMPDOWN:
  - duty_cur -= `RAMP_STEP`, saturating at 0.
  - On reaching 0: go to DEAD, load dead_cnt.
  - If target_dir returns to dir_cur: go back to RUN immediately with the current duty (no dead time).
- DEAD:
  - pwm_out=0, dir_a=dir_b=0.
  - dead_cnt decrements each boundary.
  - When dead_cnt reaches 0: dir_cur <= target_dir, go to RUN.
  - DEAD always completes, even if the command changes.

Direction outputs:
- `dir_a` = (state≠DEAD) && !dir_cur
- `dir_b` = (state≠DEAD) && dir_cur
- Never both high.

Arithmetic: ramp computed at 9 bits, then clamped to 0..255. No wrap-around.

`enable` low (checked every clk, not only at boundaries):
- next edge: duty_cur=0, pwm_out=0, state=RUN, dead_cnt=0;
- dir_cur held; prescaler and `cnt` keep running.

## Timing

- PWM period = 255·`CLK_DIV` clks.
- `pwm_out` lags `cnt` by 1 clk (registered compare).
- Latency from a cmd change to the first duty_cur change: from the next boundary up to one full period. The new duty applies from `cnt`=0 of the following period.
- Ramp from 0 to D takes ceil(D/`RAMP_STEP`) periods.
- A reversal from duty D takes ceil(D/`RAMP_STEP`) + `DEAD_PERIODS` periods before the opposite direction is driven.
- Events coinciding on the same clk:
  - `enable` low + boundary: enable wins.
  - reset_n low: overrides everything, asynchronously.

## Structure

- Package `motor_pkg`:
  - state enum {RUN, RAMPDOWN, DEAD};
  - `PWM_TOP`=254;
  - cmd field constants `CMD_DIR_BIT`=8, `CMD_DUTY_MSB`=7.
- Sub-module `motor_pwm_timebase`: prescaler plus period counter; outputs `tick`, `cnt[7:0]`, `boundary`.
- Top level instantiates two drivers, one per motor PIO.

## Test plan

Bench parameters: `CLK_DIV`=1, `RAMP_STEP`=8, `DEAD_PERIODS`=2.

1. Reset: assert reset_n low mid-run -> all outputs 0 immediately; after release, duty_cur=0, dir_a=dir_b=0 until the first boundary.
2. cmd=0x040, enable=1 -> duty_cur 8,16,…,64 over 8 periods; dir_a=1; then `pwm_out` is high for exactly 64 of 255 clks per period.
3. From duty 64, cmd=0x0FF -> last ramp step 248→255; `pwm_out` is then constantly high.
4. From forward duty 64, cmd=0x140 -> reversing=1; duty falls 56…0 over 8 periods, then 2 periods with dir_a=dir_b=pwm_out=0, then dir_b=1 and ramp 8…64.
5. During RAMPDOWN at duty 32, cmd back to 0x040 -> RUN, ramps 40…64, DEAD is never entered, dir_b is never asserted.
6. enable low mid-period at duty 128 -> `pwm_out`=0 and duty_cur=0 on the next clk; after re-enable, ramps from 0.
